// File: rtl/stream_fifo_flushable.sv
// Multi-entry valid/ready FIFO with a single-cycle synchronous flush and no fall-through.
// Optional flush drop counter enabled by defining FIFO_FLUSH_DROP_CNT_EN.
module stream_fifo_flushable #(
    parameter type T = logic [31:0],
    parameter int unsigned Depth = 4,
    localparam int unsigned UsageW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  T                  data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output T                  data_o,
`ifdef FIFO_FLUSH_DROP_CNT_EN
    output logic [15:0]       drop_cnt_o,
`endif
    output logic [UsageW-1:0] usage_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    T                  mem [Depth];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [UsageW-1:0] count;
    logic              push;
    logic              pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // ready_o depends only on state and flush_i, never on ready_i
    assign ready_o = (count != UsageW'(Depth)) && !flush_i;
    assign valid_o = (count != '0);
    assign data_o  = mem[rd_ptr];
    assign usage_o = count;
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            // storage is left untouched; only the bookkeeping is cleared
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + UsageW'(push) - UsageW'(pop);
        end
    end

`ifdef FIFO_FLUSH_DROP_CNT_EN
    logic [16:0] drop_sum;

    // a head beat popped during the flush cycle was delivered, not dropped
    assign drop_sum = {1'b0, drop_cnt_o} + 17'(count - UsageW'(pop));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
        end else if (flush_i) begin
            drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_stream_fifo_flushable.sv
// Self-checking bench for stream_fifo_flushable: directed scenarios plus random traffic
// checked every cycle against a queue-based model. Define FIFO_FLUSH_DROP_CNT_EN to cover the counter.
module tb_stream_fifo_flushable;

    localparam int unsigned DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] data_o;
    logic [2:0]  usage_o;
`ifdef FIFO_FLUSH_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    int assert_count = 0;
    int fail_count = 0;

    logic [31:0] model_q[$];
    int          model_drop = 0;
    bit          model_live = 1'b0;
    bit          fresh_reset = 1'b0;

    stream_fifo_flushable #(.T(logic [31:0]), .Depth(DEPTH)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_i(flush_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i(data_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o(data_o),
`ifdef FIFO_FLUSH_DROP_CNT_EN
        .drop_cnt_o(drop_cnt_o),
`endif
        .usage_o(usage_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveInputs(input bit v, input logic [31:0] d, input bit r, input bit f, input bit rs);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        rst_i   = rs;
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] d, input bit r, input bit f, input bit rs);
        driveInputs(v, d, r, f, rs);
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: the FIFO is a plain queue, flush empties it, occupancy is its size
    always @(posedge clk_i) begin
        bit m_push;
        bit m_pop;
        if (rst_i) begin
            model_q.delete();
            model_drop  = 0;
            model_live  = 1'b1;
            fresh_reset = 1'b1;
        end else if (model_live) begin
            m_pop  = ready_i && (model_q.size() > 0);
            m_push = valid_i && (model_q.size() < DEPTH) && !flush_i;
            if (flush_i) begin
                model_drop = model_drop + model_q.size() - int'(m_pop);
                if (model_drop > 65535) model_drop = 65535;
                model_q.delete();
            end else begin
                if (m_pop) void'(model_q.pop_front());
                if (m_push) begin
                    model_q.push_back(data_i);
                    fresh_reset = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk_i) begin
        if (model_live) begin
            checkOutput("usage_o", 32'(usage_o), 32'(model_q.size()));
            checkOutput("valid_o", 32'(valid_o), 32'(model_q.size() != 0));
            checkOutput("ready_o", 32'(ready_o), 32'((model_q.size() != DEPTH) && !flush_i));
            if (model_q.size() != 0)
                checkOutput("data_o head", data_o, model_q[0]);
            else if (fresh_reset)
                checkOutput("data_o after reset", data_o, 32'h0);
`ifdef FIFO_FLUSH_DROP_CNT_EN
            checkOutput("drop_cnt_o", 32'(drop_cnt_o), 32'(model_drop));
`endif
        end
    end

    initial begin
        // reset state
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("reset valid_o", 32'(valid_o), 32'h0);
        checkOutput("reset ready_o", 32'(ready_o), 32'h1);
        checkOutput("reset data_o", data_o, 32'h0);
        checkOutput("reset usage_o", 32'(usage_o), 32'h0);

        // fill to full with downstream stalled, then a refused fifth beat
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'hA0 + 32'(i), 0, 0, 0);
        driveInputs(1, 32'hA4, 1, 0, 0);
        #1;
        checkOutput("full ready_o with ready_i", 32'(ready_o), 32'h0);
        driveInputs(1, 32'hA4, 0, 0, 0);
        #1;
        checkOutput("full usage_o", 32'(usage_o), 32'h4);
        checkOutput("full ready_o", 32'(ready_o), 32'h0);
        checkOutput("model size full", 32'(model_q.size()), 32'h4);
        applyStimulus(1, 32'hA4, 0, 0, 0);
        checkOutput("refused beat usage_o", 32'(usage_o), 32'h4);

        // drain in order
        for (int i = 0; i < 4; i++) begin
            driveInputs(0, 0, 1, 0, 0);
            #1;
            checkOutput("drain data_o", data_o, 32'hA0 + 32'(i));
            applyStimulus(0, 0, 1, 0, 0);
        end
        checkOutput("drained valid_o", 32'(valid_o), 32'h0);

        // no fall-through on an empty FIFO
        driveInputs(1, 32'h55, 0, 0, 0);
        #1;
        checkOutput("empty push same-cycle valid_o", 32'(valid_o), 32'h0);
        applyStimulus(1, 32'h55, 0, 0, 0);
        checkOutput("empty push next valid_o", 32'(valid_o), 32'h1);
        checkOutput("empty push next data_o", data_o, 32'h55);

        // steady streaming at usage 2 across pointer wrap
        applyStimulus(1, 32'h56, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 32'hB0 + 32'(i), 1, 0, 0);
        checkOutput("stream usage_o", 32'(usage_o), 32'h2);
        checkOutput("stream head", data_o, 32'hB8);

        // flush at usage 3 with a concurrent pop and a refused push
        applyStimulus(1, 32'hC0, 0, 0, 0);
        driveInputs(1, 32'hDD, 1, 1, 0);
        #1;
        checkOutput("flush ready_o", 32'(ready_o), 32'h0);
        checkOutput("flush head delivered", data_o, 32'hB8);
        applyStimulus(1, 32'hDD, 1, 1, 0);
        driveInputs(0, 0, 0, 0, 0);
        #1;
        checkOutput("post-flush usage_o", 32'(usage_o), 32'h0);
        checkOutput("post-flush valid_o", 32'(valid_o), 32'h0);
`ifdef FIFO_FLUSH_DROP_CNT_EN
        checkOutput("post-flush drop_cnt_o", 32'(drop_cnt_o), 32'h2);
`endif

        // reset in the middle of a burst
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'hE0 + 32'(i), 0, 0, 0);
        checkOutput("pre-reset usage_o", 32'(usage_o), 32'h3);
        applyStimulus(1, 32'hE3, 0, 0, 1);
        driveInputs(0, 0, 0, 0, 0);
        #1;
        checkOutput("mid reset usage_o", 32'(usage_o), 32'h0);
        checkOutput("mid reset valid_o", 32'(valid_o), 32'h0);
        checkOutput("mid reset ready_o", 32'(ready_o), 32'h1);
`ifdef FIFO_FLUSH_DROP_CNT_EN
        checkOutput("mid reset drop_cnt_o", 32'(drop_cnt_o), 32'h0);
`endif

        // random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
